road_crash_monitor: RTL
=======================

// Module: road_crash_monitor
// PURPOSE
//   Game-state stage directly upstream of the score/timer display. Each frame it checks the
//   car's horizontal span against the current road edges, counts consecutive off-road frames,
//   and declares a crash. On a crash it drives `dead` high for a fixed number of cycles; the
//   display stage latches the best time and clears the run timer from that level.
//   It then runs a respawn delay and resumes play automatically.
// PARAMETERS
//   X_W            10  width of all pixel x coordinates
//   CAR_W          16  car width in pixels (car spans car_x .. car_x+CAR_W-1), >=1
//   GRACE_FRAMES    3  consecutive off-road frames that cause a crash, >=1
//   DEAD_HOLD       8  clk cycles `dead` stays high per crash, >=3
//   RESPAWN_FRAMES 60  frame_ticks spent in RESPAWN before play resumes, >=1
// PORTS
//   clk          in   1     100 MHz system clock
//   rst          in   1     synchronous, active-high reset
//   frame_tick   in   1     one-cycle pulse per video frame (vblank start)
//   start        in   1     one-cycle pulse (debounced button): leave IDLE
//   car_x        in   X_W   car left edge, stable around frame_tick
//   road_left    in   X_W   road left edge (inclusive)
//   road_right   in   X_W   road right edge (inclusive)
//   dead         out  1     high for exactly DEAD_HOLD cycles per crash
//   playing      out  1     high while in PLAY
//   offroad      out  1     registered off-road result of the last sampled frame
//   crash_count  out  8     crashes since reset, saturates at 255
//   state        out  2     IDLE=0, PLAY=1, CRASH=2, RESPAWN=3 (debug/LED)
// BEHAVIOUR
//   - Reset: state=IDLE; dead=0, playing=0, offroad=0, crash_count=0; strike, hold and
//     respawn counters =0. rst is sampled on clk only and overrides every other input.
//     Reset mid-CRASH drops dead on the next edge.
//   - Off-road test: comparisons use X_W+1 bits, so car_x+CAR_W-1 never wraps.
//     off = (car_x < road_left) | (car_x+CAR_W-1 > road_right) | (road_left > road_right).
//     Touching an edge exactly (car_x==road_left or right edge==road_right) is on-road.
//   - `offroad` register updates only on frame_tick cycles while in PLAY; it holds in other
//     states and clears on entry to PLAY.
//   - IDLE: outputs low. start=1 -> PLAY on next edge. A frame_tick in the same cycle is not
//     evaluated.
//   - PLAY: playing=1. On frame_tick:
//       - off=0 -> strike=0.
//       - off=1 and strike<GRACE_FRAMES-1 -> strike+1.
//       - off=1 and strike==GRACE_FRAMES-1 -> CRASH.
//     start is ignored.
//   - Entry to CRASH (same edge): dead<=1, playing<=0, hold<=0, strike<=0,
//     crash_count<=min(crash_count+1,255).
//     Latency: dead rises 1 cycle after the crash-causing frame_tick cycle.
//   - CRASH: hold increments each cycle. When hold==DEAD_HOLD-1 -> RESPAWN and dead<=0, so dead
//     is high exactly DEAD_HOLD cycles. frame_tick and start are ignored.
//   - RESPAWN: playing=0, dead=0. Each frame_tick increments the respawn counter. On the
//     RESPAWN_FRAMES-th tick -> PLAY with strike=0 and offroad=0. start is ignored.
//   - No state reaches IDLE except via rst. Each crash produces exactly one dead pulse;
//     the next crash can occur no sooner than GRACE_FRAMES frames after respawn.
//   - Counter widths: strike is clog2(GRACE_FRAMES+1), hold is clog2(DEAD_HOLD+1),
//     respawn is clog2(RESPAWN_FRAMES+1). None of these wrap.
// STRUCTURE
//   - Shared game package: state encoding constants (IDLE/PLAY/CRASH/RESPAWN) and the default
//     X_W/CAR_W, reused by the road generator, car control and VGA renderer.
//   - One sub-module, road_edge_cmp: the combinational X_W+1-bit off-road compare
//     (car_x, road_left, road_right -> off), shared with the renderer's collision tint.
//   - The FSM and counters live in this module.
// TESTING (X_W=10, CAR_W=16, GRACE=3, HOLD=8, RESPAWN=60)
//   1. Reset, then start pulse -> state=1, playing=1 next cycle; dead=0, crash_count=0.
//   2. road 100..300, car_x=200 for 10 ticks -> offroad=0, no dead.
//      car_x=285 (edge exactly 300) -> on-road.
//   3. car_x=286 for 3 ticks -> dead high 1 cycle after 3rd tick, for exactly 8 cycles;
//      crash_count=1, then state=3.
//   4. Off-road pattern on,off,on,on (car_x=90 when off-road) -> strike resets, no crash;
//      a following off-road tick crashes.
//   5. In RESPAWN, 59 ticks -> still state=3; 60th tick -> PLAY next cycle, offroad=0;
//      start pulses ignored throughout.
//   6. road_left=400, road_right=300, or car_x=1020 -> off-road, no wrap.
//      rst during CRASH -> dead=0, state=0 next edge.
//      256 crashes -> crash_count stays 255.

Source files
------------

// File: rtl/road_crash_monitor_pkg.sv
// rtl/road_crash_monitor_pkg.sv - shared game state encoding and default geometry
package road_crash_monitor_pkg;

    typedef enum logic [1:0] {
        ST_IDLE    = 2'd0,
        ST_PLAY    = 2'd1,
        ST_CRASH   = 2'd2,
        ST_RESPAWN = 2'd3
    } game_state_e;

    localparam int DEF_X_W   = 10;
    localparam int DEF_CAR_W = 16;

    function automatic logic [7:0] sat_inc8(input logic [7:0] v);
        return (v == 8'hFF) ? v : v + 8'd1;
    endfunction

endpackage

// File: rtl/road_crash_monitor_road_edge_cmp.sv
// rtl/road_crash_monitor_road_edge_cmp.sv - combinational car-vs-road off-road compare
module road_edge_cmp
    import road_crash_monitor_pkg::*;
#(
    parameter int X_W   = DEF_X_W,
    parameter int CAR_W = DEF_CAR_W
) (
    input  logic [X_W-1:0] car_x_i,
    input  logic [X_W-1:0] road_left_i,
    input  logic [X_W-1:0] road_right_i,
    output logic           off_o
);

    // One extra bit so the car's right edge never wraps past the screen width.
    localparam logic [X_W:0] SPAN = (X_W+1)'(CAR_W - 1);

    logic [X_W:0] car_l;
    logic [X_W:0] car_r;
    logic [X_W:0] edge_l;
    logic [X_W:0] edge_r;

    assign car_l  = {1'b0, car_x_i};
    assign car_r  = car_l + SPAN;
    assign edge_l = {1'b0, road_left_i};
    assign edge_r = {1'b0, road_right_i};

    assign off_o = (car_l < edge_l) | (car_r > edge_r) | (edge_l > edge_r);

endmodule

// File: rtl/road_crash_monitor.sv
// rtl/road_crash_monitor.sv - per-frame off-road strike counting, crash pulse and respawn
module road_crash_monitor
    import road_crash_monitor_pkg::*;
#(
    parameter int X_W            = DEF_X_W,
    parameter int CAR_W          = DEF_CAR_W,
    parameter int GRACE_FRAMES   = 3,
    parameter int DEAD_HOLD      = 8,
    parameter int RESPAWN_FRAMES = 60
) (
    input  logic           clk,
    input  logic           rst,
    input  logic           frame_tick,
    input  logic           start,
    input  logic [X_W-1:0] car_x,
    input  logic [X_W-1:0] road_left,
    input  logic [X_W-1:0] road_right,
    output logic           dead,
    output logic           playing,
    output logic           offroad,
    output logic [7:0]     crash_count,
    output logic [1:0]     state
);

    localparam int SW = $clog2(GRACE_FRAMES + 1);
    localparam int HW = $clog2(DEAD_HOLD + 1);
    localparam int RW = $clog2(RESPAWN_FRAMES + 1);

    localparam logic [SW-1:0] STRIKE_LAST = SW'(GRACE_FRAMES - 1);
    localparam logic [HW-1:0] HOLD_LAST   = HW'(DEAD_HOLD - 1);
    localparam logic [RW-1:0] RESP_LAST   = RW'(RESPAWN_FRAMES - 1);

    game_state_e   state_q, state_d;
    logic [SW-1:0] strike_q, strike_d;
    logic [HW-1:0] hold_q, hold_d;
    logic [RW-1:0] resp_q, resp_d;
    logic          dead_q, dead_d;
    logic          offroad_q, offroad_d;
    logic [7:0]    crash_cnt_q, crash_cnt_d;
    logic          off;

    road_edge_cmp #(
        .X_W   (X_W),
        .CAR_W (CAR_W)
    ) u_edge_cmp (
        .car_x_i      (car_x),
        .road_left_i  (road_left),
        .road_right_i (road_right),
        .off_o        (off)
    );

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q     <= ST_IDLE;
            strike_q    <= '0;
            hold_q      <= '0;
            resp_q      <= '0;
            dead_q      <= 1'b0;
            offroad_q   <= 1'b0;
            crash_cnt_q <= '0;
        end else begin
            state_q     <= state_d;
            strike_q    <= strike_d;
            hold_q      <= hold_d;
            resp_q      <= resp_d;
            dead_q      <= dead_d;
            offroad_q   <= offroad_d;
            crash_cnt_q <= crash_cnt_d;
        end
    end

    always_comb begin
        state_d     = state_q;
        strike_d    = strike_q;
        hold_d      = hold_q;
        resp_d      = resp_q;
        dead_d      = dead_q;
        offroad_d   = offroad_q;
        crash_cnt_d = crash_cnt_q;

        case (state_q)
            ST_IDLE: begin
                if (start) begin
                    state_d   = ST_PLAY;
                    strike_d  = '0;
                    offroad_d = 1'b0;
                end
            end
            ST_PLAY: begin
                if (frame_tick) begin
                    offroad_d = off;
                    if (!off) begin
                        strike_d = '0;
                    end else if (strike_q == STRIKE_LAST) begin
                        state_d     = ST_CRASH;
                        strike_d    = '0;
                        hold_d      = '0;
                        dead_d      = 1'b1;
                        crash_cnt_d = sat_inc8(crash_cnt_q);
                    end else begin
                        strike_d = strike_q + SW'(1);
                    end
                end
            end
            ST_CRASH: begin
                // Leaving on the last hold cycle keeps dead high for exactly DEAD_HOLD cycles.
                if (hold_q == HOLD_LAST) begin
                    state_d = ST_RESPAWN;
                    dead_d  = 1'b0;
                    resp_d  = '0;
                end else begin
                    hold_d = hold_q + HW'(1);
                end
            end
            ST_RESPAWN: begin
                if (frame_tick) begin
                    if (resp_q == RESP_LAST) begin
                        state_d   = ST_PLAY;
                        resp_d    = '0;
                        strike_d  = '0;
                        offroad_d = 1'b0;
                    end else begin
                        resp_d = resp_q + RW'(1);
                    end
                end
            end
            default: state_d = ST_IDLE;
        endcase
    end

    assign dead        = dead_q;
    assign playing     = (state_q == ST_PLAY);
    assign offroad     = offroad_q;
    assign crash_count = crash_cnt_q;
    assign state       = state_q;

endmodule
